// File: rtl/cpu_pio_pkg.sv
// Shared definitions for the CPU-facing PIO blocks.
//
// Holds the Avalon register addresses used by the input PIO and the
// encodings for the edge-type parameter, so the top level and any
// firmware-facing documentation agree on the same numbers.

package cpu_pio_pkg;

    // Register map of the input PIO (word addresses).
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Which transitions of the debounced input are captured.
    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-bit synchroniser and debouncer.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   in_i     in   raw asynchronous input bit
//   stable_o out  debounced, synchronised level
//
// The raw input passes through two flops before anything else looks at it.
// The debounced level only follows the synchronised input once the input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any return
// to the current level restarts the count.

module pio_debounce_bit
    import cpu_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter bit RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; on the last count the new level is accepted and the
    // counter restarts so a later change is timed from zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset loads the idle key level everywhere so a released key does not
    // look like a change immediately after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= in_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/cpu_button_pio_in.sv
// Avalon-MM input PIO for the alarm-clock push-buttons and switches.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   address     in   register select (0 DATA, 2 IRQMASK, 3 EDGECAP)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   in_port     in   raw asynchronous button/switch inputs
//   readdata    out  combinational read data, upper bits zero
//   irq         out  registered level interrupt
//
// Each bit is debounced by its own pio_debounce_bit. Edges of the debounced
// value are latched in a write-1-to-clear capture register, and the
// interrupt is the OR of captured bits that are enabled in the mask.

module cpu_button_pio_in
    import cpu_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int EDGE_TYPE       = EDGE_FALL,
    parameter bit RESET_LEVEL     = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stableDly_q;
    logic [WIDTH-1:0] edgeHit;
    logic [WIDTH-1:0] clrMask;
    logic [WIDTH-1:0] edgeCap_q;
    logic [WIDTH-1:0] edgeCap_d;
    logic [WIDTH-1:0] irqMask_q;
    logic [WIDTH-1:0] irqMask_d;
    logic             irq_q;
    logic             busWrite;
    logic             unused_wdata;

    // One synchroniser/debouncer per input bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .in_i    (in_port[i]),
            .stable_o(stable[i])
        );
    end

    assign busWrite     = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    // Edge selection compares the debounced value with its one-cycle delay.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edgeHit = ~stableDly_q & stable;
            EDGE_ANY:  edgeHit = stableDly_q ^ stable;
            default:   edgeHit = stableDly_q & ~stable;
        endcase
    end

    // Register writes. A new edge sets its capture bit even when the same
    // cycle carries a clear for that bit, so no key press is ever lost.
    always_comb begin
        clrMask   = '0;
        irqMask_d = irqMask_q;
        if (busWrite && address == ADDR_EDGECAP) begin
            clrMask = writedata[WIDTH-1:0];
        end
        if (busWrite && address == ADDR_IRQMASK) begin
            irqMask_d = writedata[WIDTH-1:0];
        end
        edgeCap_d = edgeHit | (edgeCap_q & ~clrMask);
    end

    // The edge delay register resets to the idle level so that the first
    // cycle after reset cannot produce a false edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stableDly_q <= {WIDTH{RESET_LEVEL}};
            edgeCap_q   <= '0;
            irqMask_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            stableDly_q <= stable;
            edgeCap_q   <= edgeCap_d;
            irqMask_q   <= irqMask_d;
            irq_q       <= |(edgeCap_q & irqMask_q);
        end
    end

    // Zero-latency read mux; address 1 and unused upper bits read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = stable;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqMask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgeCap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_cpu_button_pio_in.sv
// Directed testbench for cpu_button_pio_in with a short debounce window.
//
// Inputs change 1 ns after a rising edge and outputs are checked at that
// same point, well away from the next active edge.

module tb_cpu_button_pio_in;

    import cpu_pio_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEB   = 8;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int vectors;
    int miscompares;

    cpu_button_pio_in #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16),
        .EDGE_TYPE      (EDGE_FALL),
        .RESET_LEVEL    (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, ending 1 ns after the last one.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single-cycle Avalon write; it takes effect on the next rising edge.
    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        applyStimulus(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    // Zero-latency read, checked without advancing the clock.
    task automatic busRead(input string tag, input logic [1:0] addr,
                           input logic [31:0] expected);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        checkOutput(tag, readdata, expected);
        chipselect = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        address     = '0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = '0;
        in_port     = 4'hF;

        // 1. Reset then read
        $display("[TB] reset and register defaults");
        applyStimulus(2);
        checkOutput("irq_in_reset", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        busRead("rst_data", ADDR_DATA, 32'h0000_000F);
        busRead("rst_mask", ADDR_IRQMASK, 32'h0);
        busRead("rst_ecap", ADDR_EDGECAP, 32'h0);
        busRead("rst_addr1", 2'd1, 32'h0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);

        // 2. Debounce latency: 2 sync cycles plus DEB debounce cycles
        $display("[TB] debounce latency");
        in_port = 4'hE;
        applyStimulus(9);
        busRead("lat_data_9", ADDR_DATA, 32'hF);
        applyStimulus(1);
        busRead("lat_data_10", ADDR_DATA, 32'hE);
        busRead("lat_ecap_10", ADDR_EDGECAP, 32'h0);
        applyStimulus(1);
        busRead("lat_ecap_11", ADDR_EDGECAP, 32'h1);
        checkOutput("lat_irq_masked", {31'd0, irq}, 32'd0);
        busWrite(ADDR_EDGECAP, 32'h1);
        busRead("lat_ecap_clr", ADDR_EDGECAP, 32'h0);
        in_port = 4'hF;
        applyStimulus(12);
        busRead("lat_release_data", ADDR_DATA, 32'hF);
        busRead("lat_release_ecap", ADDR_EDGECAP, 32'h0);

        // 3. Glitch shorter than the debounce window
        $display("[TB] glitch rejection");
        in_port = 4'hD;
        applyStimulus(5);
        in_port = 4'hF;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1);
            busRead("glitch_data", ADDR_DATA, 32'hF);
        end
        busRead("glitch_ecap", ADDR_EDGECAP, 32'h0);
        checkOutput("glitch_irq", {31'd0, irq}, 32'd0);

        // 4. Interrupt path
        $display("[TB] interrupt path");
        busWrite(ADDR_IRQMASK, 32'h1);
        busRead("int_mask", ADDR_IRQMASK, 32'h1);
        in_port = 4'hE;
        applyStimulus(11);
        busRead("int_ecap", ADDR_EDGECAP, 32'h1);
        checkOutput("int_irq_before", {31'd0, irq}, 32'd0);
        applyStimulus(1);
        checkOutput("int_irq_rise", {31'd0, irq}, 32'd1);
        busWrite(ADDR_EDGECAP, 32'h1);
        busRead("int_ecap_clr", ADDR_EDGECAP, 32'h0);
        checkOutput("int_irq_hold", {31'd0, irq}, 32'd1);
        applyStimulus(1);
        checkOutput("int_irq_fall", {31'd0, irq}, 32'd0);
        in_port = 4'hF;
        applyStimulus(12);
        busRead("int_release_ecap", ADDR_EDGECAP, 32'h0);
        checkOutput("int_release_irq", {31'd0, irq}, 32'd0);

        // 5. Mask and clear semantics
        $display("[TB] mask and clear semantics");
        busWrite(ADDR_IRQMASK, 32'h0);
        in_port = 4'h3;
        applyStimulus(12);
        busRead("mask_ecap", ADDR_EDGECAP, 32'hC);
        busRead("mask_data", ADDR_DATA, 32'h3);
        checkOutput("mask_irq_off", {31'd0, irq}, 32'd0);
        busWrite(ADDR_IRQMASK, 32'h8);
        checkOutput("mask_irq_wr", {31'd0, irq}, 32'd0);
        applyStimulus(1);
        checkOutput("mask_irq_on", {31'd0, irq}, 32'd1);
        busWrite(ADDR_EDGECAP, 32'h4);
        busRead("mask_ecap_part", ADDR_EDGECAP, 32'h8);
        applyStimulus(1);
        checkOutput("mask_irq_still", {31'd0, irq}, 32'd1);
        busWrite(ADDR_EDGECAP, 32'h8);
        busWrite(ADDR_IRQMASK, 32'h0);
        in_port = 4'hF;
        applyStimulus(12);
        busRead("mask_release_ecap", ADDR_EDGECAP, 32'h0);
        checkOutput("mask_release_irq", {31'd0, irq}, 32'd0);

        // 6a. Clear in the same cycle as a new edge: the set wins
        $display("[TB] simultaneous set and clear");
        in_port = 4'hE;
        applyStimulus(10);
        busWrite(ADDR_EDGECAP, 32'h1);
        busRead("sim_ecap", ADDR_EDGECAP, 32'h1);
        busWrite(ADDR_EDGECAP, 32'h1);
        busRead("sim_ecap_clr", ADDR_EDGECAP, 32'h0);
        in_port = 4'hF;
        applyStimulus(12);

        // 6b. Reset while a change is still being debounced
        $display("[TB] reset mid-debounce");
        busWrite(ADDR_IRQMASK, 32'hF);
        in_port = 4'hE;
        applyStimulus(12);
        checkOutput("rst2_irq_pre", {31'd0, irq}, 32'd1);
        in_port = 4'h6;
        applyStimulus(5);
        reset_n = 1'b0;
        in_port = 4'hF;
        applyStimulus(2);
        reset_n = 1'b1;
        checkOutput("rst2_irq", {31'd0, irq}, 32'd0);
        busRead("rst2_data", ADDR_DATA, 32'hF);
        busRead("rst2_mask", ADDR_IRQMASK, 32'h0);
        busRead("rst2_ecap", ADDR_EDGECAP, 32'h0);
        applyStimulus(15);
        busRead("rst2_ecap_late", ADDR_EDGECAP, 32'h0);
        busRead("rst2_data_late", ADDR_DATA, 32'hF);
        checkOutput("rst2_irq_late", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
